// File: rtl/accumulator_6_pkg.sv
// -----------------------------------------------------------------------------
// accumulator_6_pkg
// Shared definitions for the 6-bit frame accumulator and its adder:
//   ACC_W   - operand / running-sum width
//   CNT_W   - width of the per-frame operand counter
//   state_t - frame state: ACCUM (taking operands) or HOLD (result presented)
// -----------------------------------------------------------------------------
package accumulator_6_pkg;

    localparam int ACC_W = 6;
    localparam int CNT_W = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/ripple_adder_6.sv
// -----------------------------------------------------------------------------
// ripple_adder_6
// Combinational 6-bit unsigned ripple-carry adder, carry-in tied to 0.
// Ports:
//   a, b - 6-bit addends
//   sum  - (a + b) mod 64
//   co   - carry out of bit 5
// -----------------------------------------------------------------------------
module ripple_adder_6
    import accumulator_6_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             co
);

    logic [ACC_W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[ACC_W];

endmodule

// File: rtl/accumulator_6.sv
// -----------------------------------------------------------------------------
// accumulator_6
// Folds a stream of unsigned 6-bit operands into a registered running sum.
// After TERMS accepted operands the frame total and a sticky overflow flag
// are presented and held until the downstream stage accepts them.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   clr                 - synchronous frame abort (wins over any handshake)
//   in_valid / in_ready - operand handshake; in_ready is high in ACCUM only
//   din                 - unsigned operand
//   out_valid/out_ready - result handshake; out_valid is high in HOLD only
//   acc                 - running sum, frame total while out_valid=1
//   cy                  - sticky carry out of bit 5 across the frame
//   count               - operands accepted in the current frame
// -----------------------------------------------------------------------------
module accumulator_6
    import accumulator_6_pkg::*;
#(
    parameter int WIDTH = ACC_W,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             cy,
    output logic [CNT_W-1:0] count
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             accept;
    logic             last_term;
    logic             release_hold;

    ripple_adder_6 u_adder (
        .a   (acc),
        .b   (din),
        .sum (sum),
        .co  (co)
    );

    assign accept       = in_ready & in_valid;
    assign last_term    = (count == CNT_W'(TERMS - 1));
    assign release_hold = out_valid & out_ready;

    // Handshake outputs are pure state decodes, so neither in_valid nor
    // out_ready reaches an output combinationally.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_term) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (clr) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // clr is checked first so an operand presented alongside it is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cy    <= 1'b0;
            count <= '0;
        end else if (clr || release_hold) begin
            acc   <= '0;
            cy    <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc   <= sum;
            cy    <= cy | co;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: doc/accumulator_6.md
# accumulator_6

Sequential accumulator stage directly downstream of the 6-bit ripple full adder. It accepts a stream of 6-bit operands over a valid/ready handshake and folds each one into a registered running sum. The addition goes through a combinational 6-bit adder instance. After a fixed number of terms, it presents the frame total plus a sticky overflow flag to the next stage, and holds it until that stage accepts.

## Interface
Parameters:
- WIDTH, 6, operand/sum width; fixed at 6 for this block.
- TERMS, 4, operands per frame; legal range 2..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame abort; discards the partial sum.
- in_valid  in  1  din holds a valid operand.
- in_ready  out  1  block can accept an operand this cycle.
- din  in  6  operand, unsigned.
- out_valid  out  1  acc/cy hold a completed frame result.
- out_ready  in  1  downstream accepts the result.
- acc  out  6  running sum; the frame total while out_valid=1.
- cy  out  1  sticky overflow: set if any addition in the frame carried out of bit 5.
- count  out  4  number of operands accepted in the current frame.

## Operation
- State machine has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept in ACCUM occurs when in_valid=1 and in_ready=1. On an accept:
  - acc <= (acc + din) mod 64.
  - cy <= cy | carry_out, where carry_out is the true carry out of bit 5 of that addition.
  - count <= count + 1.
- If an accept occurs with count == TERMS-1, the next state is HOLD.
- HOLD:
  - acc, cy and count are frozen; din and in_valid are ignored.
  - When out_ready=1: acc <= 0, cy <= 0, count <= 0, next state is ACCUM.
- clr=1 (any state): acc <= 0, cy <= 0, count <= 0, next state is ACCUM.
  - clr has priority over a simultaneous accept or out_ready handshake; the operand is dropped.
- Arithmetic is unsigned; the sum wraps modulo 2^6, and the wrap is recorded only through cy.

## Timing
- Reset values: state=ACCUM, acc=0, cy=0, count=0, out_valid=0, in_ready=1.
  - Outputs take these values immediately on rst assertion, independent of clk.
  - A reset mid-frame or during HOLD discards all state.
- in_ready and out_valid are decoded from state only; there is no combinational path from in_valid or out_ready.
- Latency: acc reflects an accepted operand on the cycle after the accept edge. out_valid rises on the cycle after the TERMS-th accept.
- Throughput: one operand per cycle in ACCUM. Each frame costs TERMS accept cycles plus at least one HOLD cycle.
  - Best case is TERMS+1 cycles per frame with out_ready tied high.
- Backpressure: with out_ready=0, HOLD persists indefinitely with the result stable.
- in_valid gaps in ACCUM leave acc, cy and count unchanged.

## Structure
- Shared package holds:
  - the WIDTH constant;
  - the 2-state enum (ACCUM, HOLD);
  - the count width constant (4).
- Sub-module ripple_adder_6 is combinational, with ports a[5:0], b[5:0], sum[5:0] and co (carry out of bit 5, internal carry-in 0).
  - It is instantiated once, with a=acc and b=din.
- Top level contains the state register, the acc/cy/count registers and the handshake decode only.

## Test plan
All scenarios use TERMS=4.
- Reset: assert rst between edges -> acc=0, cy=0, count=0, out_valid=0 and in_ready=1 immediately, before the next clk edge.
- Back-to-back frame with out_ready=1: din=1,2,3,4 on consecutive cycles.
  - out_valid=1 one cycle after the 4th accept, with acc=10, cy=0, count=4.
  - On the next cycle: acc=0, count=0, in_ready=1.
- Overflow:
  - din=63,1,0,0 -> result acc=0, cy=1.
  - din=40,40,40,40 -> result acc=32, cy=1.
  - din=15,16,16,16 -> result acc=63, cy=0.
- Backpressure: complete a frame with out_ready=0 for 5 cycles and in_valid=1, din=7 throughout.
  - in_ready=0 and acc/cy/count are unchanged for all 5 cycles.
  - Raising out_ready clears the result and the next frame starts from 0.
- clr mid-frame: accept 5,6, then assert clr together with in_valid=1, din=9.
  - acc=0, count=0; the 9 is dropped.
  - A subsequent frame 1,1,1,1 yields acc=4, cy=0.
- Async reset during HOLD and during ACCUM with count=2: outputs return to reset values immediately, and the following frame 2,2,2,2 yields acc=8.
